add_rkey_pipe: RTL and testbench

Parametrised, handshaked AddRoundKey stage for the AES datapath. It holds a local bank of NUM_KEYS round keys, written by the key-expansion logic. Each accepted state word is XORed with the round key selected by its round tag, then registered. It replaces the single-key, purely combinational XOR stage and adds per-round key selection, flow control and key-use error detection.

---
 rtl/add_rkey_pipe_if.sv | 46 ++++
 rtl/add_rkey_pipe.sv | 112 +++++++++++
 tb/tb_add_rkey_pipe.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/add_rkey_pipe_if.sv
// Stream and key-write bundle for the AddRoundKey stage.
// The master side drives key writes and input words and accepts output words.
// The slave side is the stage itself.
interface add_rkey_pipe_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
);
    // Round-key write port, driven by the key-expansion logic
    logic              key_we;
    logic [ADDR_W-1:0] key_addr;
    logic [DATA_W-1:0] key_din;

    // Upstream state-word stream
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ADDR_W-1:0] in_round;

    // Downstream state-word stream
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_round;

    // Key-use error reporting
    logic              key_err;
    logic              err_sticky;

    modport master (
        output key_we, key_addr, key_din,
        output in_valid, in_data, in_round,
        input  in_ready,
        input  out_valid, out_data, out_round,
        output out_ready,
        input  key_err, err_sticky
    );

    modport slave (
        input  key_we, key_addr, key_din,
        input  in_valid, in_data, in_round,
        output in_ready,
        output out_valid, out_data, out_round,
        input  out_ready,
        output key_err, err_sticky
    );
endinterface

// File: rtl/add_rkey_pipe.sv
// Handshaked AddRoundKey stage: a local bank of NUM_KEYS round keys, per-word
// key selection by round tag, a single-entry output register with full
// throughput, and detection of reads from missing or unloaded key slots.
module add_rkey_pipe #(
    parameter int DATA_W   = 128,
    parameter int NUM_KEYS = 11,
    parameter int ADDR_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    add_rkey_pipe_if.slave   bus
);

    // Slot count at index width plus one bit, so that index range tests
    // compare operands of equal width.
    localparam logic [ADDR_W:0] NUM_KEYS_W = NUM_KEYS[ADDR_W:0];

    logic [DATA_W-1:0]   key_mem [NUM_KEYS];
    logic [NUM_KEYS-1:0] loaded;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_round_q;
    logic              key_err_q;
    logic              err_sticky_q;

    logic              key_wr_ok;
    logic              round_ok;
    logic              bypass;
    logic              accept;
    logic              transfer;
    logic [DATA_W-1:0] sel_key;
    logic              key_ok;

    // Writes to slots beyond NUM_KEYS are dropped silently.
    assign key_wr_ok = bus.key_we && ({1'b0, bus.key_addr} < NUM_KEYS_W);
    assign round_ok  = {1'b0, bus.in_round} < NUM_KEYS_W;
    assign bypass    = key_wr_ok && (bus.key_addr == bus.in_round);

    // The register may take a new word whenever it is empty or draining.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign transfer     = out_valid_q && bus.out_ready;

    // Key bank and loaded bitmap; both are cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            // NOTE: the key bank is reset on purpose: stale keys must not
            // survive a reset, which costs a reset path on every bit.
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_mem[i] <= '0;
            end
            loaded <= '0;
        end else if (key_wr_ok) begin
            key_mem[bus.key_addr] <= bus.key_din;
            loaded[bus.key_addr]  <= 1'b1;
        end
    end

    // Pick the round key for the word being offered: a same-cycle write
    // wins over the stored slot; a missing or unloaded slot gives zero.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and infers a latch.
        sel_key = '0;
        key_ok  = 1'b0;
        if (bypass) begin
            sel_key = bus.key_din;
            key_ok  = 1'b1;
        end else if (round_ok && loaded[bus.in_round]) begin
            sel_key = key_mem[bus.in_round];
            key_ok  = 1'b1;
        end
    end

    // Output register: load on accept, empty after a lone transfer, hold
    // while stalled. Data and round tag are never zeroed outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            key_err_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data ^ sel_key;
            out_round_q <= bus.in_round;
            key_err_q   <= !key_ok;
        end else if (transfer) begin
            out_valid_q <= 1'b0;
            key_err_q   <= 1'b0;
        end
    end

    // Sticky error flag, set on the same edge that registers a bad word.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else if (accept && !key_ok) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_round  = out_round_q;
    assign bus.key_err    = key_err_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_add_rkey_pipe.sv
// Directed bench for add_rkey_pipe: FIPS-197 round 0, streaming, stalls,
// write bypass, key-use errors, ignored writes and reset mid-stream.
module tb_add_rkey_pipe;

    localparam int DATA_W   = 128;
    localparam int NUM_KEYS = 11;
    localparam int ADDR_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    add_rkey_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    add_rkey_pipe #(
        .DATA_W  (DATA_W),
        .NUM_KEYS(NUM_KEYS),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // One comparison point: counts the vector and reports any miscompare.
    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [DATA_W-1:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [DATA_W-1:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DATA_W-1:0] FIPS_OUT = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [DATA_W-1:0] D1       = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [DATA_W-1:0] D1_K1    = 128'h0022446688aacceeffddbb9977553311;
    localparam logic [DATA_W-1:0] D2       = 128'hf0f0f0f00f0f0f0fa5a5a5a55a5a5a5a;
    localparam logic [DATA_W-1:0] D2_K2    = 128'hf2f2f2f20d0d0d0da7a7a7a758585858;
    localparam logic [DATA_W-1:0] D3       = 128'hcafef00d123456789abcdef011223344;

    initial begin
        logic [7:0]        b;
        logic [DATA_W-1:0] rep;

        bus.key_we    = 1'b0;
        bus.key_addr  = '0;
        bus.key_din   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_round  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_out_valid",  bus.out_valid,  0);
        check("rst_out_data",   bus.out_data,   0);
        check("rst_out_round",  bus.out_round,  0);
        check("rst_key_err",    bus.key_err,    0);
        check("rst_err_sticky", bus.err_sticky, 0);
        check("rst_in_ready",   bus.in_ready,   1);

        // FIPS-197 round 0
        bus.key_we = 1'b1; bus.key_addr = 4'd0; bus.key_din = FIPS_KEY;
        step();
        bus.key_we = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = FIPS_IN; bus.in_round = 4'd0;
        step();
        bus.in_valid = 1'b0;
        check("fips_valid", bus.out_valid, 1);
        check("fips_data",  bus.out_data,  FIPS_OUT);
        check("fips_round", bus.out_round, 0);
        check("fips_err",   bus.key_err,   0);

        // Streaming: slot i holds byte i everywhere
        for (int i = 0; i < NUM_KEYS; i++) begin
            b = 8'(i);
            bus.key_we = 1'b1; bus.key_addr = 4'(i); bus.key_din = {16{b}};
            step();
        end
        bus.key_we = 1'b0;
        check("stream_idle_before", bus.out_valid, 0);
        for (int i = 0; i < NUM_KEYS; i++) begin
            bus.in_valid = 1'b1; bus.in_data = '0; bus.in_round = 4'(i);
            step();
            b = 8'(i);
            rep = {16{b}};
            check($sformatf("stream_data_%0d", i),  bus.out_data,  rep);
            check($sformatf("stream_round_%0d", i), bus.out_round, 128'(i));
            check($sformatf("stream_valid_%0d", i), bus.out_valid, 1);
            check($sformatf("stream_ready_%0d", i), bus.in_ready,  1);
        end
        bus.in_valid = 1'b0;
        step();
        check("stream_drained", bus.out_valid, 0);

        // Backpressure: word A held for three stalled cycles, B waits
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = D1; bus.in_round = 4'd1;
        step();
        bus.in_data = D2; bus.in_round = 4'd2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_data_%0d", i),  bus.out_data,  D1_K1);
            check($sformatf("stall_round_%0d", i), bus.out_round, 1);
            check($sformatf("stall_valid_%0d", i), bus.out_valid, 1);
            check($sformatf("stall_ready_%0d", i), bus.in_ready,  0);
            step();
        end
        check("stall_data_end", bus.out_data, D1_K1);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("resume_data",  bus.out_data,  D2_K2);
        check("resume_round", bus.out_round, 2);
        check("resume_valid", bus.out_valid, 1);
        step();
        check("resume_drained", bus.out_valid, 0);
        check("resume_hold_data", bus.out_data, D2_K2);

        // Write bypass on round 5
        bus.key_we = 1'b1; bus.key_addr = 4'd5; bus.key_din = '1;
        bus.in_valid = 1'b1; bus.in_data = '0; bus.in_round = 4'd5;
        step();
        bus.key_we = 1'b0; bus.in_valid = 1'b0;
        check("bypass_data", bus.out_data, '1);
        check("bypass_err",  bus.key_err,  0);
        check("bypass_sticky_clear", bus.err_sticky, 0);
        step();

        // Round 12 is beyond the key bank
        bus.in_valid = 1'b1; bus.in_data = D3; bus.in_round = 4'd12;
        step();
        bus.in_valid = 1'b0;
        check("bad_round_data",   bus.out_data,   D3);
        check("bad_round_err",    bus.key_err,    1);
        check("bad_round_sticky", bus.err_sticky, 1);
        step();
        check("bad_round_err_pulse", bus.key_err,    0);
        check("bad_round_drained",   bus.out_valid,  0);
        check("bad_round_sticky2",   bus.err_sticky, 1);

        // Write to slot 14 changes nothing
        bus.key_we = 1'b1; bus.key_addr = 4'd14; bus.key_din = D1;
        step();
        bus.key_we = 1'b0;
        check("wr14_valid",  bus.out_valid,  0);
        check("wr14_data",   bus.out_data,   D3);
        check("wr14_sticky", bus.err_sticky, 1);

        // A legal word after an error carries no error
        bus.in_valid = 1'b1; bus.in_data = '0; bus.in_round = 4'd1;
        step();
        bus.in_valid = 1'b0;
        check("legal_after_err_data",   bus.out_data,   {16{8'h01}});
        check("legal_after_err_err",    bus.key_err,    0);
        check("legal_after_err_sticky", bus.err_sticky, 1);
        step();

        // Reset while a word is stalled
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = D1; bus.in_round = 4'd2;
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid",  bus.out_valid,  0);
        check("mid_rst_sticky", bus.err_sticky, 0);
        check("mid_rst_err",    bus.key_err,    0);

        // Keys were cleared: round 0 and round 3 are now illegal
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = D2; bus.in_round = 4'd0;
        step();
        check("post_rst_r0_data",   bus.out_data,   D2);
        check("post_rst_r0_err",    bus.key_err,    1);
        check("post_rst_r0_sticky", bus.err_sticky, 1);
        bus.in_data = D3; bus.in_round = 4'd3;
        step();
        bus.in_valid = 1'b0;
        check("post_rst_r3_data",  bus.out_data,  D3);
        check("post_rst_r3_round", bus.out_round, 3);
        check("post_rst_r3_err",   bus.key_err,   1);
        step();
        check("post_rst_drained", bus.out_valid,  0);
        check("post_rst_sticky",  bus.err_sticky, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
